// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver: FSM state encoding,
// scan-code prefix bytes and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_CHECK  = 3'd4
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int unsigned PS2_EVENT_W   = 10;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through event FIFO. A push while full is dropped and
// reported on overflow unless a pop frees a slot in the same cycle.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  input  logic                     ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             overflow_r;
  logic             full_s;
  logic             pop_s;
  logic             write_s;

  assign full_s  = (level_r == FULL_LEVEL);
  assign pop_s   = (level_r != '0) && ready;
  assign write_s = push && (!full_s || pop_s);

  // Storage array; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (write_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({write_s, pop_s})
        2'b10:   level_r <= level_r + (AW+1)'(1'b1);
        2'b01:   level_r <= level_r - (AW+1)'(1'b1);
        default: level_r <= level_r;
      endcase
      overflow_r <= push && full_s && !pop_s;
    end
  end

  assign rdata    = mem_r[rd_ptr_r];
  assign valid    = (level_r != '0);
  assign overflow = overflow_r;
  assign level    = level_r;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the PS/2 lines, deframes
// 11-bit frames with parity/stop/timeout checking, optionally folds the
// E0/F0 prefixes into event flags, and queues events in a FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 16,
  parameter int DECODE         = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [9:0]                    ev_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bit DECODE_ON = (DECODE != 32'sd0);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   fall_s;
  logic                   bit_s;

  ps2_state_e             state_r;
  ps2_state_e             state_nxt_s;

  logic [7:0]             shift_r;
  logic [2:0]             bit_cnt_r;
  logic                   parity_bit_r;
  logic                   stop_bit_r;
  logic [TW-1:0]          timeout_cnt_r;
  logic                   timeout_hit_s;
  logic                   parity_ok_s;

  logic                   ext_r;
  logic                   brk_r;
  logic                   parity_err_r;
  logic                   frame_err_r;

  logic                   push_s;
  logic                   set_ext_s;
  logic                   set_brk_s;
  logic                   clr_flags_s;
  logic                   par_fail_s;
  logic                   stop_fail_s;
  logic                   tmo_fail_s;
  logic [9:0]             push_data_s;

  // Synchronise the asynchronous PS/2 lines; idle level is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_r  <= '1;
      data_sync_r <= '1;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign fall_s        = clk_sync_r[SYNC_STAGES-1] && !clk_sync_r[SYNC_STAGES-2];
  assign bit_s         = data_sync_r[SYNC_STAGES-1];
  assign timeout_hit_s = (timeout_cnt_r == TIMEOUT_LAST) && !fall_s;
  assign parity_ok_s   = odd_parity_ok(shift_r, parity_bit_r);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic: advance one frame field per PS/2 falling edge.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_s && !bit_s) state_nxt_s = ST_DATA;
        else                  state_nxt_s = ST_IDLE;
      end
      ST_DATA: begin
        if (fall_s && (bit_cnt_r == 3'd7)) state_nxt_s = ST_PARITY;
        else if (timeout_hit_s)            state_nxt_s = ST_IDLE;
        else                               state_nxt_s = ST_DATA;
      end
      ST_PARITY: begin
        if (fall_s)             state_nxt_s = ST_STOP;
        else if (timeout_hit_s) state_nxt_s = ST_IDLE;
        else                    state_nxt_s = ST_PARITY;
      end
      ST_STOP: begin
        if (fall_s)             state_nxt_s = ST_CHECK;
        else if (timeout_hit_s) state_nxt_s = ST_IDLE;
        else                    state_nxt_s = ST_STOP;
      end
      ST_CHECK: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: frame verdict, prefix handling and timeout strobes.
  always_comb begin
    push_s      = 1'b0;
    set_ext_s   = 1'b0;
    set_brk_s   = 1'b0;
    clr_flags_s = 1'b0;
    par_fail_s  = 1'b0;
    stop_fail_s = 1'b0;
    tmo_fail_s  = 1'b0;
    case (state_r)
      ST_CHECK: begin
        par_fail_s  = !parity_ok_s;
        stop_fail_s = !stop_bit_r;
        if (parity_ok_s && stop_bit_r) begin
          if (DECODE_ON && (shift_r == PS2_PREFIX_EXT)) begin
            set_ext_s = 1'b1;
          end else if (DECODE_ON && (shift_r == PS2_PREFIX_BRK)) begin
            set_brk_s = 1'b1;
          end else begin
            push_s      = 1'b1;
            clr_flags_s = 1'b1;
          end
        end else begin
          clr_flags_s = 1'b1;
        end
      end
      ST_DATA, ST_PARITY, ST_STOP: begin
        if (timeout_hit_s) begin
          tmo_fail_s  = 1'b1;
          clr_flags_s = 1'b1;
        end else begin
          tmo_fail_s  = 1'b0;
        end
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  assign push_data_s = DECODE_ON ? {ext_r, brk_r, shift_r} : {2'b00, shift_r};

  // Frame datapath: data shift register, bit counter, parity/stop capture, timeout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r       <= 8'h00;
      bit_cnt_r     <= 3'd0;
      parity_bit_r  <= 1'b0;
      stop_bit_r    <= 1'b0;
      timeout_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_DATA: begin
          if (fall_s) begin
            shift_r   <= {bit_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
          end
        end
        ST_PARITY: begin
          if (fall_s) parity_bit_r <= bit_s;
        end
        ST_STOP: begin
          if (fall_s) stop_bit_r <= bit_s;
        end
        default: begin
          bit_cnt_r <= 3'd0;
        end
      endcase
      if ((state_r == ST_DATA) || (state_r == ST_PARITY) || (state_r == ST_STOP)) begin
        timeout_cnt_r <= fall_s ? '0 : timeout_cnt_r + TW'(1'b1);
      end else begin
        timeout_cnt_r <= '0;
      end
    end
  end

  // Prefix flags carried from E0/F0 to the next ordinary byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_r <= 1'b0;
      brk_r <= 1'b0;
    end else if (clr_flags_s) begin
      ext_r <= 1'b0;
      brk_r <= 1'b0;
    end else begin
      if (set_ext_s) ext_r <= 1'b1;
      if (set_brk_s) brk_r <= 1'b1;
    end
  end

  // Registered one-cycle error pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      parity_err_r <= par_fail_s;
      frame_err_r  <= stop_fail_s || tmo_fail_s;
    end
  end

  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;

  ps2_event_fifo #(
    .WIDTH (PS2_EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_s),
    .wdata    (push_data_s),
    .rdata    (ev_data),
    .valid    (ev_valid),
    .ready    (ev_ready),
    .overflow (overflow),
    .level    (fifo_level)
  );

endmodule
